// File: rtl/usb_sie_pkg.sv
// usb_sie_pkg
// Shared definitions for the USB SIE transmit path:
//   - PID nibble codes for the DATA packet family
//   - CRC16 polynomial (reflected), initial value and good-packet residual
//   - transmit packet state enum
//   - pid_nibble(): maps the 2-bit packet selector to its PID nibble
package usb_sie_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  // x^16 + x^15 + x^2 + 1 in LSB-first (reflected) form.
  localparam logic [15:0] CRC16_POLY_REV = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  // Register value a receiver sees after running payload + both CRC bytes
  // through the same reflected engine (bit-reversed 0x800D).
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    DATA,
    CRC_LO,
    CRC_HI
  } tx_state_e;

  function automatic logic [3:0] pid_nibble(input logic [1:0] sel);
    logic [3:0] nib;
    case (sel)
      2'd0:    nib = PID_DATA0;
      2'd1:    nib = PID_DATA1;
      2'd2:    nib = PID_DATA2;
      default: nib = PID_MDATA;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/usb_data_pkt_tx_if.sv
// usb_data_pkt_tx_if
// Byte-stream handshakes around the DATA packet assembler.
//   in_*  : payload bytes from the endpoint buffer (valid/ready, in_last)
//   tx_*  : packet bytes to the bit-stuff/NRZI serializer (valid/ready, tx_eop)
// Modports:
//   slave  : the packet assembler (consumes in_*, produces tx_*)
//   master : the surroundings (endpoint buffer + serializer)
interface usb_data_pkt_tx_if;
  import usb_sie_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_eop;

  modport slave (
    input  in_data, in_valid, in_last, tx_ready,
    output in_ready, tx_data, tx_valid, tx_eop
  );

  modport master (
    output in_data, in_valid, in_last, tx_ready,
    input  in_ready, tx_data, tx_valid, tx_eop
  );

endinterface

// File: rtl/usb_crc16_step.sv
// usb_crc16_step
// Combinational byte step of the USB CRC16 (reflected 0xA001 form).
// The byte is consumed LSB first, matching the wire bit order.
//   crc_in  [15:0] : current CRC register
//   data_in [7:0]  : payload byte
//   crc_out [15:0] : CRC register after absorbing data_in
module usb_crc16_step
  import usb_sie_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] work;

  always_comb begin
    work = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      work = work[0] ? ((work >> 1) ^ CRC16_POLY_REV) : (work >> 1);
    end
    crc_out = work;
  end

endmodule

// File: rtl/usb_data_pkt_tx.sv
// usb_data_pkt_tx
// Transmit-side SIE assembler for USB 2.0 DATA0/DATA1/DATA2/MDATA packets.
// Emits PID byte, payload (pulled from the endpoint buffer), then the
// complemented CRC16 low byte and high byte. CRC covers payload only.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start           : begin a packet (honoured only in IDLE)
//   pid_sel, zlp    : packet type and zero-length flag, captured at start
//   abort           : synchronous abort back to IDLE, highest priority
//   bus (slave)     : in_* payload handshake, tx_* serializer handshake
//   busy            : not in IDLE
//   pkt_done        : CRC high byte accepted by the serializer
//   ovf_err         : payload truncated at MAX_PAYLOAD
//   byte_cnt        : payload bytes accepted in the current/last packet
module usb_data_pkt_tx
  import usb_sie_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1024,
  parameter int CNT_W       = 11
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           pid_sel,
  input  logic                 zlp,
  input  logic                 abort,
  usb_data_pkt_tx_if.slave     bus,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 ovf_err,
  output logic [CNT_W-1:0]     byte_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

  tx_state_e        state_q, state_d;
  logic [3:0]       pid_q;
  logic             zlp_q;
  logic [15:0]      crc_q;
  logic [15:0]      crc_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_q;
  logic             in_acc;
  logic             tx_acc;

  logic [7:0]       skid_data_p0;
  logic             vld_p0;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign busy     = (state_q != IDLE);
  assign byte_cnt = cnt_q;

  usb_crc16_step u_crc (
    .crc_in  (crc_q),
    .data_in (bus.in_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_eop   = 1'b0;
    pkt_done     = 1'b0;
    ovf_err      = 1'b0;
    in_acc       = 1'b0;
    tx_acc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = PID;
      end
      PID: begin
        bus.tx_data  = {~pid_q, pid_q};
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) state_d = zlp_q ? CRC_LO : DATA;
      end
      DATA: begin
        bus.tx_data  = skid_data_p0;
        bus.tx_valid = vld_p0;
        // Refill the skid slot whenever it is empty or draining this cycle;
        // gated by abort so no byte is swallowed by an aborted packet.
        bus.in_ready = !last_q && (!vld_p0 || bus.tx_ready) && !abort;
        in_acc       = bus.in_ready && bus.in_valid;
        tx_acc       = vld_p0 && bus.tx_ready;
        ovf_err      = in_acc && !bus.in_last && (cnt_inc == MAX_CNT);
        if (last_q && tx_acc) state_d = CRC_LO;
      end
      CRC_LO: begin
        bus.tx_data  = ~crc_q[7:0];
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) state_d = CRC_HI;
      end
      CRC_HI: begin
        bus.tx_data  = ~crc_q[15:8];
        bus.tx_valid = 1'b1;
        bus.tx_eop   = 1'b1;
        if (bus.tx_ready) begin
          state_d  = IDLE;
          pkt_done = !abort;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pid_q   <= 4'h0;
      zlp_q   <= 1'b0;
      crc_q   <= CRC16_INIT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        vld_p0 <= 1'b0;
        last_q <= 1'b0;
      end else if (state_q == IDLE) begin
        if (start) begin
          pid_q  <= pid_nibble(pid_sel);
          zlp_q  <= zlp;
          crc_q  <= CRC16_INIT;
          cnt_q  <= '0;
          last_q <= 1'b0;
          vld_p0 <= 1'b0;
        end
      end else if (state_q == DATA) begin
        if (in_acc) begin
          crc_q  <= crc_next;
          vld_p0 <= 1'b1;
          if (cnt_q != MAX_CNT) cnt_q <= cnt_inc;
          if (bus.in_last || (cnt_inc == MAX_CNT)) last_q <= 1'b1;
        end else if (tx_acc) begin
          vld_p0 <= 1'b0;
        end
      end
    end
  end

  // ---- stage p0: payload skid register feeding tx_data ----
  always_ff @(posedge clk) begin
    if (in_acc) skid_data_p0 <= bus.in_data;
  end

endmodule

// File: tb/tb_usb_data_pkt_tx.sv
module tb_usb_data_pkt_tx;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       eop;
  } tx_beat_t;
  typedef tx_beat_t beat_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // sel=0 drives the full-size DUT, sel=1 the MAX_PAYLOAD=4 DUT.
  logic       sel;
  logic       start, zlp, abort;
  logic [1:0] pid_sel;
  logic [7:0] in_data;
  logic       in_valid, in_last, tx_ready;

  usb_data_pkt_tx_if ifa ();
  usb_data_pkt_tx_if ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifa.in_last  = in_last;
  assign ifa.tx_ready = tx_ready;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;
  assign ifb.in_last  = in_last;
  assign ifb.tx_ready = tx_ready;

  logic        busy_a, pkt_done_a, ovf_a;
  logic [10:0] cnt_a;
  logic        busy_b, pkt_done_b, ovf_b;
  logic [2:0]  cnt_b;

  usb_data_pkt_tx dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .pid_sel(pid_sel), .zlp(zlp),
    .abort(abort), .bus(ifa), .busy(busy_a), .pkt_done(pkt_done_a),
    .ovf_err(ovf_a), .byte_cnt(cnt_a)
  );

  usb_data_pkt_tx #(.MAX_PAYLOAD(4), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .pid_sel(pid_sel), .zlp(zlp),
    .abort(abort), .bus(ifb), .busy(busy_b), .pkt_done(pkt_done_b),
    .ovf_err(ovf_b), .byte_cnt(cnt_b)
  );

  logic        m_in_ready, m_tx_valid, m_tx_eop, m_busy, m_pkt_done, m_ovf;
  logic [7:0]  m_tx_data;
  logic [10:0] m_cnt;
  assign m_in_ready = sel ? ifb.in_ready : ifa.in_ready;
  assign m_tx_valid = sel ? ifb.tx_valid : ifa.tx_valid;
  assign m_tx_eop   = sel ? ifb.tx_eop   : ifa.tx_eop;
  assign m_tx_data  = sel ? ifb.tx_data  : ifa.tx_data;
  assign m_busy     = sel ? busy_b       : busy_a;
  assign m_pkt_done = sel ? pkt_done_b   : pkt_done_a;
  assign m_ovf      = sel ? ovf_b        : ovf_a;
  assign m_cnt      = sel ? {8'h00, cnt_b} : cnt_a;

  int n_cmp = 0;
  int n_bad = 0;
  beat_q_t exp_q;
  beat_q_t no_ovr;

  int pkt_done_total = 0, ovf_total = 0, hs_total = 0, acc_total = 0, ir_total = 0;
  int acc_pkt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_idle(input string name, input int cnt);
    check({name, "_tx_valid"}, m_tx_valid, 0);
    check({name, "_in_ready"}, m_in_ready, 0);
    check({name, "_tx_eop"},   m_tx_eop, 0);
    check({name, "_tx_data"},  m_tx_data, 0);
    check({name, "_busy"},     m_busy, 0);
    check({name, "_pkt_done"}, m_pkt_done, 0);
    check({name, "_ovf_err"},  m_ovf, 0);
    check({name, "_byte_cnt"}, m_cnt, cnt);
  endtask

  // Reference CRC: message fed one bit at a time, LSB first, into the
  // reflected x^16+x^15+x^2+1 register.
  function automatic logic [15:0] ref_crc(input byte_q_t b, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic logic [3:0] ref_pid(input logic [1:0] s);
    logic [3:0] tab [4];
    tab = '{4'h3, 4'hB, 4'h7, 4'hF};
    return tab[s];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic       stalled_prev = 1'b0, abort_prev = 1'b0, prev_eop = 1'b0;
  logic [7:0] prev_data = 8'h00;
  tx_beat_t   mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      stalled_prev = 1'b0;
      acc_pkt      = 0;
    end else begin
      if (!m_busy) acc_pkt = 0;
      if (stalled_prev && !abort_prev) begin
        check("stall_tx_valid", m_tx_valid, 1);
        check("stall_tx_data",  m_tx_data, prev_data);
        check("stall_tx_eop",   m_tx_eop, prev_eop);
      end
      if (m_tx_valid && tx_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_tx_byte: actual %02h, required no byte", m_tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", m_tx_data, mon_e.data);
          check("tx_eop",  m_tx_eop,  mon_e.eop);
        end
      end
      if (m_in_ready) ir_total++;
      if (m_in_ready && in_valid) begin
        acc_total++;
        acc_pkt++;
      end
      if (m_pkt_done) begin
        pkt_done_total++;
        check("pkt_done_on_eop_accept", m_tx_valid && m_tx_eop && tx_ready, 1);
      end
      if (m_ovf) begin
        ovf_total++;
        check("ovf_with_accept", m_in_ready && in_valid, 1);
        check("ovf_at_max_accept", acc_pkt, sel ? 4 : 1024);
      end
      stalled_prev = m_tx_valid && !tx_ready;
      prev_data    = m_tx_data;
      prev_eop     = m_tx_eop;
      abort_prev   = abort;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_pkt(input logic [1:0] ps, input bit z, input byte_q_t pl, input bit use_last,
                         input int gap_pct, input int stall_pct, input bit extra_start,
                         input int abort_at, input int reset_at, input beat_q_t ovr);
    int max_pl, n, idx, cyc;
    bit done, cut, exp_ovf;
    logic [15:0] c;
    tx_beat_t b;
    int pd0, ov0, hs0, ac0, ir0;

    max_pl  = sel ? 4 : 1024;
    n       = z ? 0 : ((pl.size() < max_pl) ? pl.size() : max_pl);
    exp_ovf = !z && (use_last ? (pl.size() > max_pl) : (pl.size() >= max_pl));

    if (ovr.size() > 0) begin
      foreach (ovr[i]) exp_q.push_back(ovr[i]);
    end else begin
      b.data = {~ref_pid(ps), ref_pid(ps)}; b.eop = 1'b0; exp_q.push_back(b);
      for (int i = 0; i < n; i++) begin
        b.data = pl[i]; b.eop = 1'b0; exp_q.push_back(b);
      end
      c = ref_crc(pl, n);
      b.data = ~c[7:0];  b.eop = 1'b0; exp_q.push_back(b);
      b.data = ~c[15:8]; b.eop = 1'b1; exp_q.push_back(b);
    end

    pd0 = pkt_done_total; ov0 = ovf_total; hs0 = hs_total; ac0 = acc_total; ir0 = ir_total;

    @(posedge clk); #1;
    pid_sel = ps; zlp = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pid_sel = 2'($urandom); zlp = 1'($urandom);

    idx = 0; cyc = 0; done = 0; cut = 0;
    while (!done && !cut && cyc < 3000) begin
      tx_ready = ($urandom_range(0, 99) >= stall_pct);
      if (!z && idx < pl.size() && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1; in_data = pl[idx]; in_last = use_last && (idx == pl.size() - 1);
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
      end
      start = extra_start && (cyc == 3);
      @(negedge clk);
      if (in_valid && m_in_ready) idx++;
      if (m_pkt_done) done = 1;
      if (!done && reset_at >= 0 && idx == reset_at) begin
        #2; reset = 1'b0; #1;
        check_idle("async_reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        exp_q.delete();
        cut = 1;
      end else if (!done && abort_at >= 0 && idx == abort_at) begin
        @(posedge clk); #1;
        abort = 1'b1; tx_ready = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = pl[idx]; in_last = 1'b0;
        @(negedge clk);
        check("abort_in_ready_low", m_in_ready, 0);
        check("abort_stalled_valid", m_tx_valid, 1);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check_idle("after_abort", abort_at);
        exp_q.delete();
        cut = 1;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b0; start = 1'b0;

    if (!done && !cut) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pkt_timeout: actual no pkt_done in %0d cycles, required pkt_done", cyc);
      exp_q.delete();
    end else if (done) begin
      check("exp_queue_drained", exp_q.size(), 0);
      check("pkt_done_count", pkt_done_total - pd0, 1);
      check("ovf_count", ovf_total - ov0, exp_ovf);
      check("tx_handshakes", hs_total - hs0, n + 3);
      check("in_accepts", acc_total - ac0, n);
      check_idle("after_pkt", n);
      if (z) check("zlp_in_ready_cycles", ir_total - ir0, 0);
    end else begin
      check("cut_no_pkt_done", pkt_done_total - pd0, 0);
      if (reset_at < 0) check("abort_tx_handshakes", hs_total - hs0, abort_at);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    byte_q_t p1, pl;
    beat_q_t e1;
    tx_beat_t b;
    int len;
    bit z, ul;

    sel = 1'b0; start = 1'b0; zlp = 1'b0; abort = 1'b0; pid_sel = 2'd0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b0;

    repeat (3) @(posedge clk); #1;
    check_idle("reset_a", 0);
    sel = 1'b1; #1;
    check_idle("reset_b", 0);
    sel = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) p1.push_back(8'(8'h31 + i));
    b.data = 8'h4B; b.eop = 1'b0; e1.push_back(b);
    foreach (p1[i]) begin b.data = p1[i]; b.eop = 1'b0; e1.push_back(b); end
    b.data = 8'hC8; b.eop = 1'b0; e1.push_back(b);
    b.data = 8'hB4; b.eop = 1'b1; e1.push_back(b);

    // DATA1 "123456789", no back-pressure
    run_pkt(2'd1, 1'b0, p1, 1'b1, 0, 0, 1'b0, -1, -1, e1);
    // zero-length DATA0
    run_pkt(2'd0, 1'b1, p1, 1'b1, 0, 0, 1'b0, -1, -1, no_ovr);
    // same payload, gapped input, stalled output, extra start while busy
    run_pkt(2'd1, 1'b0, p1, 1'b1, 40, 40, 1'b1, -1, -1, e1);

    // truncation at MAX_PAYLOAD=4
    sel = 1'b1;
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    run_pkt(2'd2, 1'b0, pl, 1'b0, 0, 0, 1'b0, -1, -1, no_ovr);
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    run_pkt(2'd3, 1'b0, pl, 1'b1, 30, 30, 1'b0, -1, -1, no_ovr);
    sel = 1'b0;

    // abort during 3rd payload byte with tx stalled, then a clean packet
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    run_pkt(2'd0, 1'b0, pl, 1'b1, 0, 0, 1'b0, 3, -1, no_ovr);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", m_busy, 0);
    check("abort_start_tx_valid", m_tx_valid, 0);
    run_pkt(2'd2, 1'b0, p1, 1'b1, 20, 20, 1'b0, -1, -1, no_ovr);

    // asynchronous reset in the middle of DATA, then a clean packet
    run_pkt(2'd1, 1'b0, p1, 1'b1, 10, 30, 1'b0, -1, 4, no_ovr);
    run_pkt(2'd3, 1'b0, p1, 1'b1, 0, 0, 1'b0, -1, -1, no_ovr);

    // randomized packets on both instances
    for (int t = 0; t < 14; t++) begin
      sel = 1'($urandom_range(0, 1));
      ul  = sel ? 1'($urandom_range(0, 1)) : 1'b1;
      len = $urandom_range(0, sel ? 7 : 40);
      if (sel && !ul && len < 4) len = $urandom_range(4, 7);
      z = (len == 0) || ($urandom_range(0, 9) == 0);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      run_pkt(2'($urandom), z, pl, ul, $urandom_range(0, 50), $urandom_range(0, 50),
              1'($urandom_range(0, 1)) && !z && len > 4, -1, -1, no_ovr);
    end
    sel = 1'b0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
